// File: rtl/commit_checker_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// commit_checker_pkg: checker states, default parameters, popcount
// Rev 1.0
// ------------------------------------------------------------------
package commit_checker_pkg;

  localparam int c_NUM_CH_DEFAULT       = 5;
  localparam int c_DATA_W_DEFAULT       = 16;
  localparam int c_DEPTH_DEFAULT        = 4;
  localparam int c_TIMEOUT_DEFAULT      = 1024;
  localparam int c_STOP_ON_FAIL_DEFAULT = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    PASS  = 3'd3,
    FAIL  = 3'd4
  } state_t;

  function automatic logic [5:0] f_popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/commit_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// commit_fifo: skew FIFO, wrap-bit pointers, pop-before-push when full
// Rev 1.0
// ------------------------------------------------------------------
module commit_fifo
  import commit_checker_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEFAULT,
  parameter int DEPTH  = c_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_PW = c_AW + 1;

  logic [c_PW-1:0]   r_wp;
  logic [c_PW-1:0]   r_rp;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_do_pop;
  logic              w_do_push;

  assign empty     = (r_wp == r_rp);
  assign full      = (r_wp[c_AW] != r_rp[c_AW]) && (r_wp[c_AW-1:0] == r_rp[c_AW-1:0]);
  assign w_do_pop  = pop && !empty;
  // A full FIFO still accepts a write when its head leaves in the same cycle
  assign w_do_push = push && (!full || w_do_pop);
  assign rdata     = r_mem[r_rp[c_AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + c_PW'(1);
      if (w_do_pop)  r_rp <= r_rp + c_PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wp[c_AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/commit_checker.sv
`default_nettype none
// ------------------------------------------------------------------
// commit_checker: per-channel DUT/model record compare with run FSM
// Rev 1.0
// ------------------------------------------------------------------
module commit_checker
  import commit_checker_pkg::*;
#(
  parameter int NUM_CH       = c_NUM_CH_DEFAULT,
  parameter int DATA_W       = c_DATA_W_DEFAULT,
  parameter int DEPTH        = c_DEPTH_DEFAULT,
  parameter int TIMEOUT      = c_TIMEOUT_DEFAULT,
  parameter int STOP_ON_FAIL = c_STOP_ON_FAIL_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_CH-1:0]          dut_valid,
  input  logic [NUM_CH*DATA_W-1:0]   dut_data,
  input  logic [NUM_CH-1:0]          ref_valid,
  input  logic [NUM_CH*DATA_W-1:0]   ref_data,
  input  logic                       dut_hlt,
  input  logic                       ref_hlt,
  output logic                       mismatch,
  output logic [$clog2(NUM_CH)-1:0]  first_ch,
  output logic [DATA_W-1:0]          first_dut,
  output logic [DATA_W-1:0]          first_ref,
  output logic [15:0]                err_count,
  output logic [31:0]                compare_count,
  output logic                       overflow,
  output logic                       timeout,
  output logic [2:0]                 state,
  output logic                       pass,
  output logic                       fail
);

  localparam int c_CH_W   = $clog2(NUM_CH);
  localparam int c_IDLE_W = $clog2(TIMEOUT + 1);

  state_t              r_state;
  logic                r_pass, r_fail, r_mismatch, r_ovf, r_tmo;
  logic                r_dut_hlt, r_ref_hlt;
  logic [c_CH_W-1:0]   r_first_ch;
  logic [DATA_W-1:0]   r_first_dut, r_first_ref;
  logic [15:0]         r_err;
  logic [31:0]         r_cmp;
  logic [c_IDLE_W-1:0] r_idle;

  logic [NUM_CH-1:0]   w_push_dut, w_push_ref, w_pop, w_neq;
  logic [NUM_CH-1:0]   w_dut_full, w_dut_empty, w_ref_full, w_ref_empty;
  logic [DATA_W-1:0]   w_dut_head [NUM_CH];
  logic [DATA_W-1:0]   w_ref_head [NUM_CH];
  logic                w_active, w_any_neq, w_ovf, w_activity, w_any_push, w_all_empty;
  logic                w_tmo_hit, w_force_fail, w_dut_h, w_ref_h;
  logic [5:0]          w_n_cmp, w_n_err;
  logic [16:0]         w_err_sum;
  logic [c_IDLE_W-1:0] w_idle_inc;
  logic [c_CH_W-1:0]   w_sel_ch;
  logic [DATA_W-1:0]   w_sel_dut, w_sel_ref;

  assign w_active = (r_state == RUN) || (r_state == DRAIN);

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_push_dut[g] = w_active && dut_valid[g];
      assign w_push_ref[g] = w_active && ref_valid[g];
      assign w_pop[g]      = w_active && !w_dut_empty[g] && !w_ref_empty[g];
      assign w_neq[g]      = w_pop[g] && (w_dut_head[g] != w_ref_head[g]);

      commit_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push_dut[g]),
        .pop   (w_pop[g]),
        .wdata (dut_data[g*DATA_W +: DATA_W]),
        .rdata (w_dut_head[g]),
        .full  (w_dut_full[g]),
        .empty (w_dut_empty[g])
      );

      commit_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ref_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push_ref[g]),
        .pop   (w_pop[g]),
        .wdata (ref_data[g*DATA_W +: DATA_W]),
        .rdata (w_ref_head[g]),
        .full  (w_ref_full[g]),
        .empty (w_ref_empty[g])
      );
    end
  endgenerate

  // Descending scan so the lowest mismatching channel is the last write
  always_comb begin
    w_sel_ch  = '0;
    w_sel_dut = '0;
    w_sel_ref = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_neq[i]) begin
        w_sel_ch  = c_CH_W'(i);
        w_sel_dut = w_dut_head[i];
        w_sel_ref = w_ref_head[i];
      end
    end
  end

  assign w_any_neq   = |w_neq;
  assign w_any_push  = (|w_push_dut) || (|w_push_ref);
  assign w_activity  = w_any_push || (|w_pop);
  assign w_all_empty = (&w_dut_empty) && (&w_ref_empty);
  assign w_ovf       = |((w_push_dut & w_dut_full & ~w_pop) | (w_push_ref & w_ref_full & ~w_pop));
  assign w_n_cmp     = f_popcount(32'(w_pop));
  assign w_n_err     = f_popcount(32'(w_neq));
  assign w_err_sum   = {1'b0, r_err} + {11'd0, w_n_err};
  assign w_idle_inc  = r_idle + c_IDLE_W'(1);
  assign w_tmo_hit   = w_active && !w_activity && (w_idle_inc == c_IDLE_W'(TIMEOUT));
  assign w_force_fail = w_ovf || w_tmo_hit || (w_any_neq && (STOP_ON_FAIL != 0));
  assign w_dut_h     = r_dut_hlt || dut_hlt;
  assign w_ref_h     = r_ref_hlt || ref_hlt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_mismatch  <= 1'b0;
      r_ovf       <= 1'b0;
      r_tmo       <= 1'b0;
      r_dut_hlt   <= 1'b0;
      r_ref_hlt   <= 1'b0;
      r_first_ch  <= '0;
      r_first_dut <= '0;
      r_first_ref <= '0;
      r_err       <= '0;
      r_cmp       <= '0;
      r_idle      <= '0;
    end else begin
      if (w_active) begin
        r_cmp  <= r_cmp + {26'd0, w_n_cmp};
        r_err  <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        r_idle <= w_activity ? '0 : w_idle_inc;
        if (w_any_neq) begin
          r_mismatch <= 1'b1;
          if (!r_mismatch) begin
            r_first_ch  <= w_sel_ch;
            r_first_dut <= w_sel_dut;
            r_first_ref <= w_sel_ref;
          end
        end
        if (w_ovf)     r_ovf     <= 1'b1;
        if (w_tmo_hit) r_tmo     <= 1'b1;
        if (dut_hlt)   r_dut_hlt <= 1'b1;
        if (ref_hlt)   r_ref_hlt <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (start) r_state <= RUN;
        end
        RUN, DRAIN: begin
          if (w_force_fail) begin
            r_state <= FAIL;
            r_fail  <= 1'b1;
          end else if ((r_state == RUN) && w_dut_h && w_ref_h) begin
            r_state <= DRAIN;
          end else if ((r_state == DRAIN) && w_all_empty && !w_any_push) begin
            if (r_mismatch) begin
              r_state <= FAIL;
              r_fail  <= 1'b1;
            end else begin
              r_state <= PASS;
              r_pass  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mismatch      = r_mismatch;
  assign first_ch      = r_first_ch;
  assign first_dut     = r_first_dut;
  assign first_ref     = r_first_ref;
  assign err_count     = r_err;
  assign compare_count = r_cmp;
  assign overflow      = r_ovf;
  assign timeout       = r_tmo;
  assign state         = r_state;
  assign pass          = r_pass;
  assign fail          = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_commit_checker.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_commit_checker: directed scoreboard bench, stop and no-stop DUTs
// Rev 1.0
// ------------------------------------------------------------------
module tb_commit_checker;
  import commit_checker_pkg::*;

  localparam int NCH = 5;
  localparam int DW  = 16;
  localparam int TMO = 8;

  logic              clk;
  logic              rst, start, dut_hlt, ref_hlt;
  logic [NCH-1:0]    dut_valid, ref_valid;
  logic [NCH*DW-1:0] dut_data, ref_data;

  logic        a_mismatch, a_overflow, a_timeout, a_pass, a_fail;
  logic [2:0]  a_first_ch, a_state;
  logic [DW-1:0] a_first_dut, a_first_ref;
  logic [15:0] a_err;
  logic [31:0] a_cmp;
  logic        b_mismatch, b_overflow, b_timeout, b_pass, b_fail;
  logic [2:0]  b_first_ch, b_state;
  logic [DW-1:0] b_first_dut, b_first_ref;
  logic [15:0] b_err;
  logic [31:0] b_cmp;

  commit_checker #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(4), .TIMEOUT(TMO), .STOP_ON_FAIL(1)) u_a (
    .clk(clk), .rst(rst), .start(start),
    .dut_valid(dut_valid), .dut_data(dut_data), .ref_valid(ref_valid), .ref_data(ref_data),
    .dut_hlt(dut_hlt), .ref_hlt(ref_hlt),
    .mismatch(a_mismatch), .first_ch(a_first_ch), .first_dut(a_first_dut), .first_ref(a_first_ref),
    .err_count(a_err), .compare_count(a_cmp), .overflow(a_overflow), .timeout(a_timeout),
    .state(a_state), .pass(a_pass), .fail(a_fail)
  );

  commit_checker #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(4), .TIMEOUT(TMO), .STOP_ON_FAIL(0)) u_b (
    .clk(clk), .rst(rst), .start(start),
    .dut_valid(dut_valid), .dut_data(dut_data), .ref_valid(ref_valid), .ref_data(ref_data),
    .dut_hlt(dut_hlt), .ref_hlt(ref_hlt),
    .mismatch(b_mismatch), .first_ch(b_first_ch), .first_dut(b_first_dut), .first_ref(b_first_ref),
    .err_count(b_err), .compare_count(b_cmp), .overflow(b_overflow), .timeout(b_timeout),
    .state(b_state), .pass(b_pass), .fail(b_fail)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic sb_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    start     = 1'b0;
    dut_hlt   = 1'b0;
    ref_hlt   = 1'b0;
    dut_valid = '0;
    ref_valid = '0;
    dut_data  = '0;
    ref_data  = '0;
  endtask

  task automatic rec(input bit side_ref, input int ch, input logic [DW-1:0] v);
    if (side_ref) begin
      ref_valid[ch]          = 1'b1;
      ref_data[ch*DW +: DW]  = v;
    end else begin
      dut_valid[ch]          = 1'b1;
      dut_data[ch*DW +: DW]  = v;
    end
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic halts();
    dut_hlt = 1'b1;
    ref_hlt = 1'b1;
    cyc();
    dut_hlt = 1'b0;
    ref_hlt = 1'b0;
  endtask

  task automatic wait_done(input bit use_b);
    for (int i = 0; i < 30; i++) begin
      if (use_b ? (b_pass || b_fail) : (a_pass || a_fail)) break;
      cyc();
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_in();

    // Reset state
    do_reset();
    expect_v("rst_state", IDLE);      sb_chk(32'(a_state));
    expect_v("rst_pass", 0);          sb_chk(32'(a_pass));
    expect_v("rst_fail", 0);          sb_chk(32'(a_fail));
    expect_v("rst_mismatch", 0);      sb_chk(32'(a_mismatch));
    expect_v("rst_cmp", 0);           sb_chk(a_cmp);
    expect_v("rst_err", 0);           sb_chk(32'(a_err));

    // Lockstep on channel 2
    do_start();
    expect_v("ls_run", RUN);          sb_chk(32'(a_state));
    rec(0, 2, 16'h1234); rec(1, 2, 16'h1234); cyc();
    clear_in();
    rec(0, 2, 16'h5678); rec(1, 2, 16'h5678); cyc();
    clear_in();
    expect_v("ls_cmp", 2);
    expect_v("ls_state", PASS);
    expect_v("ls_pass", 1);
    expect_v("ls_mismatch", 0);
    halts();
    wait_done(0);
    sb_chk(a_cmp); sb_chk(32'(a_state)); sb_chk(32'(a_pass)); sb_chk(32'(a_mismatch));

    // Skew on channel 0, preceded by a record offered while still IDLE
    do_reset();
    rec(0, 0, 16'hDEAD); cyc(); clear_in();
    do_start();
    rec(0, 0, 16'h0011); cyc();
    rec(0, 0, 16'h0022); cyc();
    rec(0, 0, 16'h0033); cyc();
    clear_in();
    rec(1, 0, 16'h0011); cyc();
    rec(1, 0, 16'h0022); cyc();
    rec(1, 0, 16'h0033); cyc();
    clear_in();
    expect_v("sk_ovf", 0);
    expect_v("sk_cmp", 3);
    expect_v("sk_mismatch", 0);
    expect_v("sk_state", PASS);
    cyc();
    halts();
    wait_done(0);
    sb_chk(32'(a_overflow)); sb_chk(a_cmp); sb_chk(32'(a_mismatch)); sb_chk(32'(a_state));

    // Mismatch with stop-on-fail on channel 1
    do_reset();
    do_start();
    rec(0, 1, 16'h00AA); rec(1, 1, 16'h00AB); cyc();
    clear_in();
    expect_v("mm_state_before", RUN); sb_chk(32'(a_state));
    expect_v("mm_state", FAIL);
    expect_v("mm_fail", 1);
    expect_v("mm_first_ch", 1);
    expect_v("mm_first_dut", 32'h00AA);
    expect_v("mm_first_ref", 32'h00AB);
    expect_v("mm_err", 1);
    cyc();
    sb_chk(32'(a_state)); sb_chk(32'(a_fail)); sb_chk(32'(a_first_ch));
    sb_chk(32'(a_first_dut)); sb_chk(32'(a_first_ref)); sb_chk(32'(a_err));

    // Simultaneous mismatches on ch3 and ch0 without stop-on-fail
    do_reset();
    do_start();
    rec(0, 0, 16'h0001); rec(1, 0, 16'h0002);
    rec(0, 3, 16'h0003); rec(1, 3, 16'h0004); cyc();
    clear_in();
    expect_v("sim_state", RUN);
    expect_v("sim_first_ch", 0);
    expect_v("sim_first_dut", 1);
    expect_v("sim_first_ref", 2);
    expect_v("sim_err", 2);
    cyc();
    sb_chk(32'(b_state)); sb_chk(32'(b_first_ch)); sb_chk(32'(b_first_dut));
    sb_chk(32'(b_first_ref)); sb_chk(32'(b_err));
    rec(0, 2, 16'h0007); rec(1, 2, 16'h0007); cyc();
    clear_in();
    expect_v("sim_cmp", 3);
    cyc();
    sb_chk(b_cmp);
    expect_v("sim_end_state", FAIL);
    expect_v("sim_end_pass", 0);
    expect_v("sim_end_err", 2);
    halts();
    wait_done(1);
    sb_chk(32'(b_state)); sb_chk(32'(b_pass)); sb_chk(32'(b_err));

    // Overflow: five DUT records into a four-deep FIFO on channel 4
    do_reset();
    do_start();
    for (int i = 1; i <= 4; i++) begin
      rec(0, 4, 16'(i)); cyc();
    end
    expect_v("of_before", 0);         sb_chk(32'(a_overflow));
    rec(0, 4, 16'h0005); cyc();
    clear_in();
    expect_v("of_flag", 1);           sb_chk(32'(a_overflow));
    expect_v("of_state", FAIL);       sb_chk(32'(a_state));

    // Timeout after TMO idle cycles in RUN
    do_reset();
    do_start();
    for (int i = 0; i < TMO - 1; i++) cyc();
    expect_v("to_state_before", RUN); sb_chk(32'(a_state));
    expect_v("to_flag_before", 0);    sb_chk(32'(a_timeout));
    cyc();
    expect_v("to_flag", 1);           sb_chk(32'(a_timeout));
    expect_v("to_state", FAIL);       sb_chk(32'(a_state));

    // Asynchronous reset in the middle of RUN, then confirm FIFOs were flushed
    do_reset();
    do_start();
    rec(0, 0, 16'h0001); rec(1, 0, 16'h0002); cyc();
    clear_in();
    cyc();
    expect_v("ar_pre_mismatch", 1);   sb_chk(32'(b_mismatch));
    rec(0, 1, 16'h0055); cyc();
    clear_in();
    #2;
    rst = 1'b1;
    #1;
    expect_v("ar_state", IDLE);       sb_chk(32'(b_state));
    expect_v("ar_mismatch", 0);       sb_chk(32'(b_mismatch));
    expect_v("ar_err", 0);            sb_chk(32'(b_err));
    expect_v("ar_cmp", 0);            sb_chk(b_cmp);
    expect_v("ar_first_ref", 0);      sb_chk(32'(b_first_ref));
    cyc();
    rst = 1'b0;
    do_start();
    rec(1, 1, 16'h0055); cyc();
    clear_in();
    cyc();
    expect_v("ar_flushed_cmp", 0);    sb_chk(b_cmp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
